// File: rtl/tt_um_restador_serial.sv
// Bit-serial subtractor tile: D = A - B, one difference bit per clock, LSB first.
// Operands are captured on a rising edge of uio_in[0]. A single full-subtractor
// cell plus a borrow flop produces each bit. Results and flags appear on uo_out.
module tt_um_restador_serial #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Operand bits beyond WIDTH are never used, so they are masked at capture.
    localparam logic [3:0] OPERAND_MASK = 4'((1 << WIDTH) - 1);
    localparam logic [1:0] LAST_BIT     = 2'(WIDTH - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] a_sr;
    logic [3:0] b_sr;
    logic [3:0] res;
    logic [3:0] res_shifted;
    logic [1:0] cnt;
    logic       bor;
    logic       bor_next;
    logic       start_q;
    logic       start_rise;
    logic       a0;
    logic       b0;
    logic       d;
    logic       unused_inputs;

    assign start_rise = uio_in[0] & ~start_q;
    assign a0         = a_sr[0];
    assign b0         = b_sr[0];

    // The full-subtractor cell: difference bit and the borrow into the next bit.
    assign d        = a0 ^ b0 ^ bor;
    assign bor_next = (~a0 & b0) | (~(a0 ^ b0) & bor);

    // The new difference bit enters at the top of the active WIDTH bits. After
    // WIDTH shifts, the LSB-first bits end up in their natural positions.
    always_comb begin
        res_shifted            = res >> 1;
        res_shifted[WIDTH - 1] = d;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE always lasts a single cycle. A start edge is only
    // honoured while already sitting in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_rise) state_next = SHIFT;
            SHIFT:   if (cnt == LAST_BIT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture the operands on start, then shift one bit per cycle.
    // The start sample is tracked in every state, so a held level never retriggers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= 4'd0;
            b_sr    <= 4'd0;
            res     <= 4'd0;
            bor     <= 1'b0;
            cnt     <= 2'd0;
            start_q <= 1'b0;
        end else begin
            start_q <= uio_in[0];
            if (state == IDLE && start_rise) begin
                a_sr <= ui_in[3:0] & OPERAND_MASK;
                b_sr <= ui_in[7:4] & OPERAND_MASK;
                bor  <= 1'b0;
                cnt  <= 2'd0;
            end else if (state == SHIFT) begin
                res  <= res_shifted;
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                bor  <= bor_next;
                cnt  <= cnt + 2'd1;
            end
        end
    end

    assign uo_out  = {(state == SHIFT) & d, state == DONE, state == SHIFT, bor, res};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // The enable and the spare bidirectional inputs have no function in this tile.
    assign unused_inputs = &{1'b0, ena, uio_in[7:1]};

endmodule

// File: doc/tt_um_restador_serial.md
Name: tt_um_restador_serial

Overview:
- Bit-serial 4-bit subtractor (D = A − B), the inverse of the team's combinational 1-bit full adder.
- Captures A and B from the dedicated inputs on a start edge, then computes one difference bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Presents the difference, final borrow and status flags on the dedicated outputs.
- Sits as a standalone Tiny Tapeout user tile.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 1..4, limited by the pin map.

Ports:
- clk  input  1  system clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  tile enable; always 1 when powered; ignored.
- ui_in  input  8  [3:0] = operand A, [7:4] = operand B; for WIDTH<4, only the low WIDTH bits of each nibble are used.
- uo_out  output  8  [3:0] = difference D (zero-extended above WIDTH); [4] = borrow_out; [5] = busy; [6] = done; [7] = current serial difference bit.
- uio_in  input  8  [0] = start (level, rising-edge detected); [7:1] unused.
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0 (all bidirectional pins are inputs).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE.
  - A/B shift registers, result register, borrow flop, bit counter and start_q (previous start sample) clear to 0.
  - uo_out = 8'h00.
- Start detect: start_rise = uio_in[0] & ~start_q, with start_q registered every cycle. No synchroniser is required; inputs are quasi-static from the bench/pins.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: on start_rise, latch A=ui_in[3:0], B=ui_in[7:4], clear borrow, clear counter, go to SHIFT. Otherwise stay.
  - SHIFT: each clock, with a0/b0 = operand LSBs:
    - d = a0 ^ b0 ^ bor.
    - bor_next = (~a0 & b0) | (~(a0 ^ b0) & bor).
    - Shift d into the result MSB; shift A and B right by one; counter increments.
    - On the edge where counter reaches WIDTH−1, go to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- Outputs:
  - busy = 1 in SHIFT only.
  - done = 1 in DONE only (one-cycle pulse).
  - uo_out[7] = the d being computed in the current SHIFT cycle; 0 outside SHIFT.
  - D and borrow_out reflect the result register and borrow flop at all times. They are final and valid from the DONE cycle onward and held until the next accepted start.
- Latency: start_rise sampled at edge k → SHIFT occupies cycles k+1..k+WIDTH → done high in cycle k+WIDTH+1. Total WIDTH+1 clocks from start edge to done.
- Arithmetic: D = (A − B) mod 2^WIDTH; borrow_out = 1 iff A < B (unsigned).
- Boundary conditions:
  - start_rise while in SHIFT or DONE: ignored, no restart. start_q still tracks, so a level held high across DONE does not retrigger.
  - start held high indefinitely: exactly one operation.
  - start rising in the same cycle the FSM returns to IDLE: not accepted. A new rising edge is required in IDLE.
  - ui_in changes during SHIFT: no effect, because operands are captured at start.
  - rst_n asserted mid-SHIFT: immediate abort, all outputs 0. After release, IDLE waits for a fresh start_rise.
  - ena = 0: no effect.

Test Plan:
- Reset, then A=9, B=3, start pulse → busy for 4 cycles; serial bits 0,1,1,0; done in cycle 5 with D=6, borrow_out=0; uo_out=8'h46.
- A=3, B=9 → D=4'b1010 (10), borrow_out=1; done cycle uo_out=8'h5A.
- Corner operands:
  - A=0, B=1 → D=15, borrow=1.
  - A=15, B=15 → D=0, borrow=0.
  - A=0, B=0 → D=0, borrow=0.
- start held high for 20 cycles with A=7, B=2 → exactly one done pulse, D=5. A second rising edge during SHIFT has no effect.
- rst_n pulled low at SHIFT cycle 2 of A=12, B=5 → uo_out=0 immediately. After release, no activity until a new start; then 12−5 gives D=7, borrow=0.
- Exhaustive sweep of all 256 A/B pairs against a reference model, checking D, borrow_out, the 5-cycle done latency, and uio_out = uio_oe = 0 throughout.
